// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen
// -----------------------------------------------------------------------------
// OV7670-compatible pixel-stream transmitter (RGB565, two bytes per pixel,
// high byte first). Generates pclk/href/vsync/data exactly as the camera does,
// with four built-in test patterns, so capture controllers and frame buffers
// can be brought up without a physical sensor.
//
// Ports:
//   clk         in   system clock; one clk per pclk half-period
//   reset       in   asynchronous, active-low reset
//   enable      in   run frames while high
//   pattern_sel in   [1:0] 0 colour bars, 1 solid, 2 gradient, 3 checker
//   solid_rgb   in   [15:0] RGB565 value for the solid pattern
//   pclk        out  generated pixel clock (clk/2), held low in IDLE
//   href        out  line-active qualifier
//   vsync       out  frame sync, active high
//   data        out  [7:0] pixel byte (0 when href is low)
//   busy        out  high from frame start until frame_done
//   frame_done  out  one-clk pulse at the end of each frame
//   frame_sum   out  [15:0] byte checksum of the last completed frame
//
// Optional feature: define OV_GEN_SUM_EN to build the frame checksum
// accumulator. Without it frame_sum is tied to 16'h0000.
//
// Structure: the *_reg position registers (state, phase, slot, line) always
// describe the byte slot currently on the outputs. The combinational block
// computes the next position, and every output is derived from that next
// position and registered, so outputs change in lock-step with the position
// and there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module ov7670_stream_gen #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int H_BLANK    = 16,
  parameter int VSYNC_LEN  = 3,
  parameter int V_BACK     = 17,
  parameter int V_FRONT    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        pclk,
  output logic        href,
  output logic        vsync,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_sum
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int ACT_SLOTS  = 2 * IMG_WIDTH;
  localparam int LINE_SLOTS = ACT_SLOTS + H_BLANK;
  localparam int BAR_W      = IMG_WIDTH / 8;
  localparam int SLOT_W     = $clog2(LINE_SLOTS);
  localparam int MAX_A      = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
  localparam int MAX_B      = (IMG_HEIGHT > V_FRONT) ? IMG_HEIGHT : V_FRONT;
  localparam int MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LINE_W     = $clog2(MAX_LINES + 1);
  localparam int BAR_CW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST    = SLOT_W'(LINE_SLOTS - 1);
  localparam logic [SLOT_W-1:0] ACT_END      = SLOT_W'(ACT_SLOTS);
  localparam logic [LINE_W-1:0] VSYNC_LAST   = LINE_W'(VSYNC_LEN - 1);
  localparam logic [LINE_W-1:0] VBACK_LAST   = LINE_W'((V_BACK > 0) ? (V_BACK - 1) : 0);
  localparam logic [LINE_W-1:0] ACTIVE_LAST  = LINE_W'(IMG_HEIGHT - 1);
  localparam logic [LINE_W-1:0] VFRONT_LAST  = LINE_W'(V_FRONT - 1);
  localparam logic [BAR_CW-1:0] BAR_LAST     = BAR_CW'(BAR_W - 1);
  // Mask selecting bit 3 of the line index; collapses to zero when the line
  // counter is narrower than four bits (bit 3 is then always 0).
  localparam logic [LINE_W-1:0] Y_BIT3_MASK  = LINE_W'(8);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  // ---------------------------------------------------------------------------
  // Position registers and their next values
  // ---------------------------------------------------------------------------
  state_t              state_reg, state_next;
  logic                phase_reg, phase_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next;
  logic [LINE_W-1:0]   line_reg, line_next;
  logic [LINE_W-1:0]   line_last;
  logic [BAR_CW-1:0]   bar_cnt_reg, bar_cnt_next;
  logic [2:0]          bar_idx_reg, bar_idx_next;

  // Frame-constant pattern selection, captured on VSYNC entry
  logic [1:0]          pat_reg;
  logic [15:0]         solid_reg;

  // Registered outputs
  logic                pclk_reg;
  logic                href_reg;
  logic                vsync_reg;
  logic [7:0]          data_reg;
  logic                busy_reg;
  logic                frame_done_reg;

  // Events and output precursors
  logic                start_frame;
  logic                frame_end;
  logic                running_next;
  logic                href_next;
  logic [7:0]          data_next;
  logic [15:0]         pixel;
  logic [15:0]         bar_rgb;
  logic [5:0]          x_lo;
  logic                y_bit3;

  // Number of lines in the current region, minus one
  always_comb begin
    line_last = VFRONT_LAST;
    case (state_reg)
      ST_VSYNC:  line_last = VSYNC_LAST;
      ST_VBACK:  line_last = VBACK_LAST;
      ST_ACTIVE: line_last = ACTIVE_LAST;
      default:   line_last = VFRONT_LAST;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-position / state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    slot_next    = slot_reg;
    line_next    = line_reg;
    start_frame  = 1'b0;
    frame_end    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Phase is always 0 in IDLE, so a start is always phase-aligned.
        phase_next = 1'b0;
        slot_next  = '0;
        line_next  = '0;
        if (enable) begin
          state_next  = ST_VSYNC;
          start_frame = 1'b1;
        end
      end

      default: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else begin
          phase_next = 1'b0;
          if (slot_reg == SLOT_LAST) begin
            slot_next = '0;
            if (line_reg == line_last) begin
              line_next = '0;
              case (state_reg)
                ST_VSYNC:  state_next = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
                ST_VBACK:  state_next = ST_ACTIVE;
                ST_ACTIVE: state_next = ST_VFRONT;
                default: begin
                  // End of VFRONT: frame is complete. Restarting here in the
                  // same clk keeps back-to-back frames gapless.
                  frame_end = 1'b1;
                  if (enable) begin
                    state_next  = ST_VSYNC;
                    start_frame = 1'b1;
                  end else begin
                    state_next  = ST_IDLE;
                  end
                end
              endcase
            end else begin
              line_next = line_reg + LINE_W'(1);
            end
          end else begin
            slot_next = slot_reg + SLOT_W'(1);
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Colour-bar tracking: a bar-width counter follows the pixel column of the
  // next slot, so the bar index is available without a divider. The column
  // advances on every even slot (start of a new pixel).
  // ---------------------------------------------------------------------------
  always_comb begin
    bar_cnt_next = bar_cnt_reg;
    bar_idx_next = bar_idx_reg;
    if (slot_next == '0) begin
      bar_cnt_next = '0;
      bar_idx_next = 3'd0;
    end else if ((slot_next != slot_reg) && !slot_next[0]) begin
      if (bar_cnt_reg == BAR_LAST) begin
        bar_cnt_next = '0;
        bar_idx_next = bar_idx_reg + 3'd1;
      end else begin
        bar_cnt_next = bar_cnt_reg + BAR_CW'(1);
      end
    end
  end

  always_comb begin
    bar_rgb = 16'h0000;
    case (bar_idx_next)
      3'd0: bar_rgb = 16'hFFFF;
      3'd1: bar_rgb = 16'hFFE0;
      3'd2: bar_rgb = 16'h07FF;
      3'd3: bar_rgb = 16'h07E0;
      3'd4: bar_rgb = 16'hF81F;
      3'd5: bar_rgb = 16'hF800;
      3'd6: bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel / byte generation for the next slot
  // ---------------------------------------------------------------------------
  always_comb begin
    x_lo   = 6'(slot_next >> 1);
    y_bit3 = |(line_next & Y_BIT3_MASK);
    pixel  = 16'h0000;
    case (pat_reg)
      2'd0: pixel = bar_rgb;
      2'd1: pixel = solid_reg;
      2'd2: pixel = {x_lo[4:0], x_lo[5:0], x_lo[4:0]};
      default: pixel = (x_lo[3] ^ y_bit3) ? 16'hFFFF : 16'h0000;
    endcase
  end

  always_comb begin
    running_next = (state_next != ST_IDLE);
    href_next    = (state_next == ST_ACTIVE) && (slot_next < ACT_END);
    data_next    = 8'h00;
    if (href_next) begin
      data_next = slot_next[0] ? pixel[7:0] : pixel[15:8];
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= 1'b0;
      slot_reg       <= '0;
      line_reg       <= '0;
      bar_cnt_reg    <= '0;
      bar_idx_reg    <= 3'd0;
      pat_reg        <= 2'd0;
      solid_reg      <= 16'h0000;
      pclk_reg       <= 1'b0;
      href_reg       <= 1'b0;
      vsync_reg      <= 1'b0;
      data_reg       <= 8'h00;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      slot_reg       <= slot_next;
      line_reg       <= line_next;
      bar_cnt_reg    <= bar_cnt_next;
      bar_idx_reg    <= bar_idx_next;
      if (start_frame) begin
        pat_reg      <= pattern_sel;
        solid_reg    <= solid_rgb;
      end
      pclk_reg       <= running_next & phase_next;
      href_reg       <= href_next;
      vsync_reg      <= (state_next == ST_VSYNC);
      data_reg       <= data_next;
      // busy drops for the frame_done clk even when the next frame starts.
      busy_reg       <= running_next & ~frame_end;
      frame_done_reg <= frame_end;
    end
  end

  assign pclk       = pclk_reg;
  assign href       = href_reg;
  assign vsync      = vsync_reg;
  assign data       = data_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

  // ---------------------------------------------------------------------------
  // Optional frame checksum: 16-bit modular sum of every byte emitted with
  // href high. A new byte is emitted on each transition into phase 0.
  // ---------------------------------------------------------------------------
`ifdef OV_GEN_SUM_EN
  logic [15:0] sum_reg;
  logic [15:0] frame_sum_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_reg       <= 16'h0000;
      frame_sum_reg <= 16'h0000;
    end else begin
      if (frame_end) begin
        frame_sum_reg <= sum_reg;
      end
      if (start_frame) begin
        sum_reg <= 16'h0000;
      end else if (href_next && !phase_next) begin
        sum_reg <= sum_reg + {8'h00, data_next};
      end
    end
  end

  assign frame_sum = frame_sum_reg;
`else
  assign frame_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Self-checking bench for ov7670_stream_gen using a reduced geometry
// (16x10 pixels, 36 slots/line, 15 lines/frame = 1080 clk/frame).
module tb_ov7670_stream_gen;

  localparam int W     = 16;
  localparam int H     = 10;
  localparam int HB    = 4;
  localparam int VL    = 2;
  localparam int VB    = 1;
  localparam int VF    = 2;
  localparam int SLOTS = 2 * W + HB;
  localparam int FRAME = 2 * SLOTS * (VL + VB + H + VF);
  localparam int NV    = 21;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb;
  logic        pclk;
  logic        href;
  logic        vsync;
  logic [7:0]  data;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_sum;

  ov7670_stream_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .H_BLANK    (HB),
    .VSYNC_LEN  (VL),
    .V_BACK     (VB),
    .V_FRONT    (VF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .pclk        (pclk),
    .href        (href),
    .vsync       (vsync),
    .data        (data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_sum   (frame_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // ---------------- stream monitor (samples on falling clk edge) -------------
  logic [7:0] cap [0:H-1][0:2*W-1];
  int  line_len [0:H-1];
  int  y_cnt, bidx, gap_cnt, gap_last, vs_cnt, vs_last, lines_last;
  int  fd_cnt, fd_last, fd_prev, data_nz;
  logic href_prev, busy_at_fd, vsync_at_fd;

  always @(negedge clk) begin
    if (!reset) begin
      y_cnt = 0; bidx = 0; gap_cnt = 0; gap_last = 0; vs_cnt = 0; vs_last = 0;
      lines_last = 0; fd_cnt = 0; fd_last = 0; fd_prev = 0; data_nz = 0;
      href_prev = 1'b0; busy_at_fd = 1'b0; vsync_at_fd = 1'b0;
    end else begin
      if (frame_done) begin
        fd_cnt++;
        fd_prev = fd_last;
        fd_last = cyc;
        lines_last = y_cnt;
        y_cnt = 0;
        vs_last = vs_cnt;
        vs_cnt = 0;
        busy_at_fd = busy;
        vsync_at_fd = vsync;
      end
      if (vsync) vs_cnt++;
      if (pclk) begin
        if (href) begin
          if (!href_prev) begin
            if (y_cnt > 0) gap_last = gap_cnt;
            y_cnt++;
            bidx = 0;
          end
          if (y_cnt >= 1 && y_cnt <= H && bidx < 2 * W) cap[y_cnt-1][bidx] = data;
          bidx++;
          if (y_cnt >= 1 && y_cnt <= H) line_len[y_cnt-1] = bidx;
          gap_cnt = 0;
        end else begin
          if (href_prev) gap_cnt = 1;
          else if (gap_cnt > 0) gap_cnt++;
          if (data !== 8'h00) data_nz++;
        end
        href_prev = href;
      end
    end
  end

  // ---------------- helpers --------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_fd(input int n);
    int t;
    t = 0;
    while (fd_cnt < n && t < 3 * FRAME) begin
      @(negedge clk); #1;
      t++;
    end
    check($sformatf("frame_done_%0d_reached", n), 32'(fd_cnt >= n), 32'd1);
  endtask

  task automatic wait_line(input int n);
    int t;
    t = 0;
    while (y_cnt < n && t < 3 * FRAME) begin
      @(negedge clk); #1;
      t++;
    end
    check($sformatf("reach_line_%0d", n), 32'(y_cnt >= n), 32'd1);
  endtask

  typedef struct {
    int          pat;
    int          x;
    int          y;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [0:NV-1];

  task automatic run_table(input int pat);
    logic [15:0] got;
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].pat == pat) begin
        got = {cap[tbl[i].y][2*tbl[i].x], cap[tbl[i].y][2*tbl[i].x+1]};
        check($sformatf("pat%0d_x%0d_y%0d", pat, tbl[i].x, tbl[i].y), 32'(got), 32'(tbl[i].exp));
      end
    end
  endtask

  // ---------------- test sequence --------------------------------------------
  initial begin
    int start_cyc;
    int bad;
    int toggles;
    int t;
    logic [15:0] exp_sum3, exp_sum4;

    // colour bars (bar width 2 pixels)
    tbl[0]  = '{0,  0, 0, 16'hFFFF};
    tbl[1]  = '{0,  1, 0, 16'hFFFF};
    tbl[2]  = '{0,  2, 0, 16'hFFE0};
    tbl[3]  = '{0,  5, 3, 16'h07FF};
    tbl[4]  = '{0,  6, 0, 16'h07E0};
    tbl[5]  = '{0,  8, 9, 16'hF81F};
    tbl[6]  = '{0, 10, 0, 16'hF800};
    tbl[7]  = '{0, 12, 4, 16'h001F};
    tbl[8]  = '{0, 15, 0, 16'h0000};
    tbl[9]  = '{0,  3, 9, 16'hFFE0};
    // gradient {x[4:0], x[5:0], x[4:0]}
    tbl[10] = '{2,  0, 0, 16'h0000};
    tbl[11] = '{2,  1, 2, 16'h0821};
    tbl[12] = '{2,  8, 5, 16'h4108};
    tbl[13] = '{2, 15, 9, 16'h79EF};
    // checker x[3]^y[3]
    tbl[14] = '{3,  0, 0, 16'h0000};
    tbl[15] = '{3,  8, 0, 16'hFFFF};
    tbl[16] = '{3,  7, 3, 16'h0000};
    tbl[17] = '{3, 15, 7, 16'hFFFF};
    tbl[18] = '{3,  0, 8, 16'hFFFF};
    tbl[19] = '{3,  8, 9, 16'h0000};
    tbl[20] = '{3,  9, 8, 16'h0000};

`ifdef OV_GEN_SUM_EN
    exp_sum3 = 16'h9F60;  // 80 white pixels * 510
    exp_sum4 = 16'h2BC0;  // 160 pixels * (0x12+0x34)
`else
    exp_sum3 = 16'h0000;
    exp_sum4 = 16'h0000;
`endif

    // Reset held with enable high: everything stays at 0.
    reset = 1'b0; enable = 1'b1; pattern_sel = 2'd0; solid_rgb = 16'h0000;
    repeat (4) @(negedge clk);
    check("rst_pclk",       32'(pclk),       32'd0);
    check("rst_href",       32'(href),       32'd0);
    check("rst_vsync",      32'(vsync),      32'd0);
    check("rst_data",       32'(data),       32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_sum",  32'(frame_sum),  32'd0);

    enable = 1'b0; reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_pclk", 32'(pclk),  32'd0);
    check("idle_busy", 32'(busy),  32'd0);

    // Frame 1: colour bars; vsync/busy rise on the enable sampling edge.
    pattern_sel = 2'd0; enable = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    check("start_vsync", 32'(vsync), 32'd1);
    check("start_busy",  32'(busy),  32'd1);
    check("start_pclk0", 32'(pclk),  32'd0);
    @(negedge clk);
    check("start_pclk1", 32'(pclk),  32'd1);

    wait_line(1);
    pattern_sel = 2'd2;   // must not affect the frame in progress
    wait_fd(1);
    check("frame1_len",      32'(fd_last - start_cyc), 32'(FRAME));
    check("frame1_lines",    32'(lines_last),          32'(H));
    check("line0_bytes",     32'(line_len[0]),         32'(2 * W));
    check("line_last_bytes", 32'(line_len[H-1]),       32'(2 * W));
    check("hblank_slots",    32'(gap_last),            32'(HB));
    check("vsync_clks",      32'(vs_last),             32'(VL * 2 * SLOTS));
    check("fd_busy_low",     32'(busy_at_fd),          32'd0);
    check("fd_gapless_vs",   32'(vsync_at_fd),         32'd1);
    run_table(0);

    // Frame 2: gradient.
    wait_line(1);
    pattern_sel = 2'd3;
    wait_fd(2);
    check("frame_period",  32'(fd_last - fd_prev), 32'(FRAME));
    check("frame2_lines",  32'(lines_last),        32'(H));
    check("frame2_vsync",  32'(vs_last),           32'(VL * 2 * SLOTS));
    run_table(2);

    // Frame 3: checker; switch to solid 1234 mid-frame.
    wait_line(1);
    pattern_sel = 2'd1; solid_rgb = 16'h1234;
    wait_fd(3);
    run_table(3);
    check("sum_checker", 32'(frame_sum), 32'(exp_sum3));

    // Frame 4: solid; enable dropped mid-ACTIVE, frame must still complete.
    wait_line(5);
    enable = 1'b0;
    wait_fd(4);
    check("frame4_lines", 32'(lines_last), 32'(H));
    bad = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (cap[y][2*x] !== 8'h12 || cap[y][2*x+1] !== 8'h34) bad++;
    check("solid_bad_pixels", 32'(bad), 32'd0);
    check("fd_stop_vsync",    32'(vsync_at_fd), 32'd0);
    check("sum_solid",        32'(frame_sum),   32'(exp_sum4));

    // Back in IDLE: no pclk activity, no further frames.
    toggles = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (pclk) toggles++;
    end
    check("idle_pclk_highs", 32'(toggles), 32'd0);
    check("idle_fd_count",   32'(fd_cnt),  32'd4);
    check("idle_busy_after", 32'(busy),    32'd0);

    // Asynchronous reset in the middle of ACTIVE with pclk high.
    enable = 1'b1;
    wait_line(1);
    t = 0;
    while (!(pclk && href) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("pre_rst_pclk_href", 32'(pclk && href), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_href",  32'(href),  32'd0);
    check("arst_vsync", 32'(vsync), 32'd0);
    check("arst_pclk",  32'(pclk),  32'd0);
    check("arst_busy",  32'(busy),  32'd0);
    check("arst_data",  32'(data),  32'd0);
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle_pclk", 32'(pclk), 32'd0);

    check("data_zero_when_href_low", 32'(data_nz), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ov7670_stream_gen.md
# ov7670_stream_gen

- Synthesisable OV7670-compatible pixel-stream transmitter: drives `pclk`/`href`/`vsync`/`data` exactly as the camera does in RGB565 mode, with built-in test patterns.
- It is the transmit end of the camera capture interface. It feeds the OV7670 capture controllers and frame buffers for on-board bring-up and simulation without a physical sensor.
- Frames are `IMG_WIDTH`×`IMG_HEIGHT`, two bytes per pixel, high byte first.

## Interface

Parameters:
- `IMG_WIDTH`, 160, active pixels per line; must be a multiple of 8.
- `IMG_HEIGHT`, 120, active lines per frame.
- `H_BLANK`, 16, byte slots with `href` low after each line's active bytes; must be ≥1.
- `VSYNC_LEN`, 3, lines with `vsync` high at frame start; must be ≥1.
- `V_BACK`, 17, blank lines after vsync.
- `V_FRONT`, 10, blank lines after the last active line; must be ≥1.

Ports:
- `clk`  in  1  system clock; one clk per pclk half-period.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run frames while high.
- `pattern_sel`  in  2  0 colour bars, 1 solid, 2 gradient, 3 checker.
- `solid_rgb`  in  16  RGB565 value used by the solid pattern.
- `pclk`  out  1  generated pixel clock (clk/2).
- `href`  out  1  line-active qualifier.
- `vsync`  out  1  frame sync, active high.
- `data`  out  8  pixel byte.
- `busy`  out  1  high from frame start until `frame_done`.
- `frame_done`  out  1  one-clk pulse at the end of each frame.
- `frame_sum`  out  16  checksum of the last completed frame (see Configuration).

## Operation

- A byte slot is 2 clk: phase 0 drives `pclk`=0 and updates `data`/`href`/`vsync`; phase 1 drives `pclk`=1. Receivers sample on the `pclk` rise.
- Every line, active or blank, is `2*IMG_WIDTH + H_BLANK` slots long.
- FSM states:
  - IDLE → VSYNC on `enable`=1 at phase 0.
  - VSYNC (`VSYNC_LEN` lines, `vsync`=1).
  - VBACK (`V_BACK` lines; skipped when the count is 0).
  - ACTIVE (`IMG_HEIGHT` lines).
  - VFRONT (`V_FRONT` lines).
  - At the end of VFRONT: `frame_done` pulses, then go to VSYNC if `enable`=1, else IDLE.
- In ACTIVE, `href`=1 for the first `2*IMG_WIDTH` slots of each line. Slot 2k carries pixel[15:8] of pixel x=k; slot 2k+1 carries pixel[7:0].
- When `href`=0, `data`=8'h00.
- `pattern_sel` and `solid_rgb` are latched on entry to VSYNC and held constant for the whole frame.
- Patterns (x = pixel column, y = active line index, both from 0):
  - Bars: 8 bars, each `IMG_WIDTH/8` pixels wide, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Generate with a bar-width counter; no divider.
  - Solid: the latched `solid_rgb`.
  - Gradient: {x[4:0], x[5:0], x[4:0]}.
  - Checker: FFFF when x[3]^y[3]=1, else 0000.
- Deasserting `enable` mid-frame does not truncate the frame; it ends after VFRONT.
- `pclk` toggles only while not in IDLE and is held at 0 in IDLE.

## Timing

- Reset values: `pclk`=0, `href`=0, `vsync`=0, `data`=0, `busy`=0, `frame_done`=0, `frame_sum`=0; FSM in IDLE.
- Reset is asserted asynchronously, takes effect immediately, and drops any partial frame.
- The first `vsync` rise occurs 1 clk after the `enable`=1 sampling edge.
- `busy` rises on that same edge.
- Frame length is `2*(2*IMG_WIDTH+H_BLANK)*(VSYNC_LEN+V_BACK+IMG_HEIGHT+V_FRONT)` clk. With defaults this is 672 clk/line × 150 lines = 100800 clk.
- `frame_done` is asserted in the clk after the final phase-1 of VFRONT; `busy` falls in that same clk.
- With `enable` held high, the next VSYNC begins in the same clk as `frame_done`, giving a gapless back-to-back stream.
- Outputs are registered; no combinational path from any input to any output.

## Configuration

- With `OV_GEN_SUM_EN` defined:
  - A 16-bit modular sum of all `data` bytes sampled while `href`=1 accumulates during the frame.
  - `frame_sum` updates with that sum in the clk `frame_done` is asserted.
  - The accumulator clears on VSYNC entry.
- Without `OV_GEN_SUM_EN`: no accumulator is built and `frame_sum` is tied to 16'h0000.

## Test plan

- Reset check: hold `reset`=0 with `enable`=1 → all outputs 0. Assert reset mid-ACTIVE → `href`, `vsync`, `pclk` return to 0 within the same cycle.
- Colour bars, defaults: first active line → 320 `href`-high slots. Bytes 0–1 = FF,FF; byte 40 (x=20, bar 1) = FF,E0 pair; bytes 318–319 = 00,00. Exactly 16 slots low between lines.
- Frame timing, defaults: `vsync` high 3×672 clk, `frame_done` period 100800 clk, 120 `href` pulses per frame.
- `enable` dropped at line 50 of ACTIVE → frame completes all 120 lines, `frame_done` pulses once, then IDLE with `pclk` held at 0.
- `pattern_sel` changed from 3 to 1 mid-frame with `solid_rgb`=16'h1234 → current frame stays checker. The next frame carries only 12,34 byte pairs.
- With `OV_GEN_SUM_EN`, `IMG_WIDTH`=8, `IMG_HEIGHT`=1, pattern solid with `solid_rgb`=16'hFFFF → `frame_sum` = 16×255 = 16'h0FF0.
